// File: rtl/npu_pkg.sv
// npu_pkg: shared widths, MAC tag bundle and helpers for the NPU PE chain.
// Contents: NPU_* width defaults, npu_ctx_w(), npu_saturate(), npu_tag_t.
package npu_pkg;

    localparam int NPU_DATA_W    = 16;
    localparam int NPU_WEIGHT_W  = 16;
    localparam int NPU_ACC_W     = 48;
    localparam int NPU_MAX_CTX_W = 8;
    localparam int NPU_MAX_ACC_W = 128;

    // ctx is carried at a fixed width; the PE narrows it to CTX_W
    typedef struct packed {
        logic [NPU_MAX_CTX_W-1:0] ctx;
        logic                     is_local;
        logic                     is_last;
        logic                     valid;
    } npu_tag_t;

    function automatic int npu_ctx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp x into the signed range of a w-bit value; ovf flags a clamp.
    function automatic logic signed [NPU_MAX_ACC_W-1:0] npu_saturate(
        input  logic signed [NPU_MAX_ACC_W:0] x,
        input  int                            w,
        output logic                          ovf
    );
        logic signed [NPU_MAX_ACC_W:0] one;
        logic signed [NPU_MAX_ACC_W:0] hi;
        logic signed [NPU_MAX_ACC_W:0] lo;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one << (w - 1)) - one;
        lo     = -hi - one;
        ovf    = 1'b0;
        npu_saturate = x[NPU_MAX_ACC_W-1:0];
        if (x > hi) begin
            npu_saturate = hi[NPU_MAX_ACC_W-1:0];
            ovf = 1'b1;
        end else if (x < lo) begin
            npu_saturate = lo[NPU_MAX_ACC_W-1:0];
            ovf = 1'b1;
        end
    endfunction

endpackage

// File: rtl/npu_pe_mul_pipe.sv
// npu_pe_mul_pipe: STAGES-deep signed multiplier with enable (DSP-friendly).
// Ports: CLK, npu_rst, npu_pe_en, mul_a, mul_b in; mul_p out (A_W+B_W bits).
module npu_pe_mul_pipe #(
    parameter int A_W    = 16,
    parameter int B_W    = 16,
    parameter int STAGES = 2
) (
    input  logic                      CLK,
    input  logic                      npu_rst,
    input  logic                      npu_pe_en,
    input  logic signed [A_W-1:0]     mul_a,
    input  logic signed [B_W-1:0]     mul_b,
    output logic signed [A_W+B_W-1:0] mul_p
);

    localparam int P_W = A_W + B_W;

    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;
    logic signed [P_W-1:0] p_c;

    assign p_c = P_W'(a_q) * P_W'(b_q);

    // Operand register is the first of the STAGES registers
    always_ff @(posedge CLK) begin
        if (npu_rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (npu_pe_en) begin
            a_q <= mul_a;
            b_q <= mul_b;
        end
    end

    generate
        if (STAGES == 1) begin : g_comb
            assign mul_p = p_c;
        end else begin : g_pipe
            logic signed [P_W-1:0] p_q [STAGES-1];
            always_ff @(posedge CLK) begin
                if (npu_rst) begin
                    for (int i = 0; i < STAGES - 1; i++) p_q[i] <= '0;
                end else if (npu_pe_en) begin
                    p_q[0] <= p_c;
                    for (int i = 1; i < STAGES - 1; i++) p_q[i] <= p_q[i-1];
                end
            end
            assign mul_p = p_q[STAGES-2];
        end
    endgenerate

endmodule

// File: rtl/npu_pe_mctx.sv
// npu_pe_mctx: multi-context MAC PE; data store, pipelined multiply, local acc.
// Ports: CLK, npu_rst, npu_pe_en, data write (wren/wr_ctx/data_in), MAC issue
// (in_valid/ctx/local/last/weight/acc_in); results out_valid/out_ctx/acc_val/
// acc_output/out_last/out_ovf. Define NPU_PE_SAT_EN for saturating sums.
module npu_pe_mctx
    import npu_pkg::*;
#(
    parameter int DATA_W     = NPU_DATA_W,
    parameter int WEIGHT_W   = NPU_WEIGHT_W,
    parameter int ACC_W      = NPU_ACC_W,
    parameter int NUM_CTX    = 4,
    parameter int MUL_STAGES = 2,
    localparam int CTX_W     = npu_ctx_w(NUM_CTX)
) (
    input  logic                       CLK,
    input  logic                       npu_rst,
    input  logic                       npu_pe_en,
    input  logic                       npu_pe_new_input_wren,
    input  logic [CTX_W-1:0]           npu_pe_wr_ctx,
    input  logic signed [DATA_W-1:0]   npu_pe_data_in,
    input  logic                       npu_pe_in_valid,
    input  logic [CTX_W-1:0]           npu_pe_in_ctx,
    input  logic                       npu_pe_in_local,
    input  logic                       npu_pe_in_last,
    input  logic signed [WEIGHT_W-1:0] npu_pe_weight_in,
    input  logic signed [ACC_W-1:0]    npu_pe_acc_in,
    output logic                       npu_pe_out_valid,
    output logic [CTX_W-1:0]           npu_pe_out_ctx,
    output logic signed [ACC_W-1:0]    npu_pe_acc_val,
    output logic signed [ACC_W-1:0]    npu_pe_acc_output,
    output logic                       npu_pe_out_last,
    output logic                       npu_pe_out_ovf
);

    localparam int P_W = DATA_W + WEIGHT_W;

    logic signed [DATA_W-1:0] data_mem  [NUM_CTX];
    logic signed [ACC_W-1:0]  local_acc [NUM_CTX];
    npu_tag_t                 tag_pipe  [MUL_STAGES];
    logic signed [ACC_W-1:0]  acc_pipe  [MUL_STAGES];

    npu_tag_t                 tag_in;
    npu_tag_t                 tag_f;
    logic [CTX_W-1:0]         ctx_f;
    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W:0]    sum_wide;
    logic signed [ACC_W-1:0]  sum;

    // Issue reads the pre-write value of the same context
    always_ff @(posedge CLK) begin
        if (npu_rst) begin
            for (int i = 0; i < NUM_CTX; i++) data_mem[i] <= '0;
        end else if (npu_pe_en && npu_pe_new_input_wren) begin
            data_mem[npu_pe_wr_ctx] <= npu_pe_data_in;
        end
    end

    npu_pe_mul_pipe #(
        .A_W    (DATA_W),
        .B_W    (WEIGHT_W),
        .STAGES (MUL_STAGES)
    ) u_mul (
        .CLK       (CLK),
        .npu_rst   (npu_rst),
        .npu_pe_en (npu_pe_en),
        .mul_a     (data_mem[npu_pe_in_ctx]),
        .mul_b     (npu_pe_weight_in),
        .mul_p     (prod)
    );

    always_comb begin
        tag_in          = '0;
        tag_in.ctx      = NPU_MAX_CTX_W'(npu_pe_in_ctx);
        tag_in.is_local = npu_pe_in_local;
        tag_in.is_last  = npu_pe_in_last;
        tag_in.valid    = npu_pe_in_valid;
    end

    // Tags and cascade addend travel beside the multiplier registers
    always_ff @(posedge CLK) begin
        if (npu_rst) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                tag_pipe[i] <= '0;
                acc_pipe[i] <= '0;
            end
        end else if (npu_pe_en) begin
            tag_pipe[0] <= tag_in;
            acc_pipe[0] <= npu_pe_acc_in;
            for (int i = 1; i < MUL_STAGES; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
                acc_pipe[i] <= acc_pipe[i-1];
            end
        end
    end

    assign tag_f    = tag_pipe[MUL_STAGES-1];
    assign ctx_f    = CTX_W'(tag_f.ctx);
    // local_acc is read and written in this stage, so no forwarding needed
    assign addend   = tag_f.is_local ? local_acc[ctx_f]
                                     : acc_pipe[MUL_STAGES-1];
    assign sum_wide = (ACC_W+1)'(prod) + (ACC_W+1)'(addend);

`ifdef NPU_PE_SAT_EN
    logic signed [NPU_MAX_ACC_W-1:0] sat_full;
    logic                            sat_ovf;
    logic                            ovf_q;

    always_comb begin
        sat_ovf  = 1'b0;
        sat_full = npu_saturate((NPU_MAX_ACC_W+1)'(sum_wide), ACC_W, sat_ovf);
    end

    assign sum = ACC_W'(sat_full);

    always_ff @(posedge CLK) begin
        if (npu_rst) begin
            ovf_q <= 1'b0;
        end else if (npu_pe_en) begin
            ovf_q <= tag_f.valid & sat_ovf;
        end
    end

    assign npu_pe_out_ovf = ovf_q;
`else
    assign sum            = ACC_W'(sum_wide);
    assign npu_pe_out_ovf = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (npu_rst) begin
            npu_pe_out_valid  <= 1'b0;
            npu_pe_out_ctx    <= '0;
            npu_pe_out_last   <= 1'b0;
            npu_pe_acc_val    <= '0;
            npu_pe_acc_output <= '0;
            for (int i = 0; i < NUM_CTX; i++) local_acc[i] <= '0;
        end else if (npu_pe_en) begin
            npu_pe_out_valid <= tag_f.valid;
            npu_pe_out_ctx   <= ctx_f;
            npu_pe_out_last  <= tag_f.valid & tag_f.is_last;
            if (tag_f.valid) begin
                npu_pe_acc_val <= sum;
                // last term hands off and re-arms the context for the next neuron
                if (tag_f.is_local) begin
                    local_acc[ctx_f] <= tag_f.is_last ? '0 : sum;
                end
                if (tag_f.is_last) begin
                    npu_pe_acc_output <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_npu_pe_mctx.sv
// tb_npu_pe_mctx: vector table plus hand sequences for stall and reset,
// checked through an expected-result queue.
module tb_npu_pe_mctx;

    localparam int DATA_W   = 16;
    localparam int WEIGHT_W = 16;
    localparam int ACC_W    = 48;
    localparam int NUM_CTX  = 4;
    localparam int CTX_W    = 2;

    localparam longint PMAX = 64'sd140737488355327;
    localparam longint NMIN = -64'sd140737488355328;

`ifdef NPU_PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                       CLK = 1'b0;
    logic                       npu_rst;
    logic                       npu_pe_en;
    logic                       npu_pe_new_input_wren;
    logic [CTX_W-1:0]           npu_pe_wr_ctx;
    logic signed [DATA_W-1:0]   npu_pe_data_in;
    logic                       npu_pe_in_valid;
    logic [CTX_W-1:0]           npu_pe_in_ctx;
    logic                       npu_pe_in_local;
    logic                       npu_pe_in_last;
    logic signed [WEIGHT_W-1:0] npu_pe_weight_in;
    logic signed [ACC_W-1:0]    npu_pe_acc_in;
    logic                       npu_pe_out_valid;
    logic [CTX_W-1:0]           npu_pe_out_ctx;
    logic signed [ACC_W-1:0]    npu_pe_acc_val;
    logic signed [ACC_W-1:0]    npu_pe_acc_output;
    logic                       npu_pe_out_last;
    logic                       npu_pe_out_ovf;

    npu_pe_mctx #(
        .DATA_W     (DATA_W),
        .WEIGHT_W   (WEIGHT_W),
        .ACC_W      (ACC_W),
        .NUM_CTX    (NUM_CTX),
        .MUL_STAGES (2)
    ) dut (
        .CLK                   (CLK),
        .npu_rst               (npu_rst),
        .npu_pe_en             (npu_pe_en),
        .npu_pe_new_input_wren (npu_pe_new_input_wren),
        .npu_pe_wr_ctx         (npu_pe_wr_ctx),
        .npu_pe_data_in        (npu_pe_data_in),
        .npu_pe_in_valid       (npu_pe_in_valid),
        .npu_pe_in_ctx         (npu_pe_in_ctx),
        .npu_pe_in_local       (npu_pe_in_local),
        .npu_pe_in_last        (npu_pe_in_last),
        .npu_pe_weight_in      (npu_pe_weight_in),
        .npu_pe_acc_in         (npu_pe_acc_in),
        .npu_pe_out_valid      (npu_pe_out_valid),
        .npu_pe_out_ctx        (npu_pe_out_ctx),
        .npu_pe_acc_val        (npu_pe_acc_val),
        .npu_pe_acc_output     (npu_pe_acc_output),
        .npu_pe_out_last       (npu_pe_out_last),
        .npu_pe_out_ovf        (npu_pe_out_ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic                       wren;
        logic [CTX_W-1:0]           wr_ctx;
        logic signed [DATA_W-1:0]   wdata;
        logic                       iv;
        logic [CTX_W-1:0]           ctx;
        logic                       loc;
        logic                       last;
        logic signed [WEIGHT_W-1:0] w;
        logic signed [ACC_W-1:0]    acc;
        logic signed [ACC_W-1:0]    exp_val;
        logic                       exp_ovf;
    } vec_t;

    typedef struct {
        logic [CTX_W-1:0]        ctx;
        logic signed [ACC_W-1:0] val;
        logic                    last;
        logic                    ovf;
    } exp_t;

    exp_t                    sb[$];
    int                      n_chk    = 0;
    int                      n_fail   = 0;
    logic signed [ACC_W-1:0] last_out = '0;
    logic signed [ACC_W-1:0] last_val = '0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input bit wren, input int wc, input int wd,
                                input bit iv, input int c, input bit loc,
                                input bit last, input int w, input longint acc,
                                input longint ev, input bit eo);
        mk.wren    = wren;
        mk.wr_ctx  = wc[CTX_W-1:0];
        mk.wdata   = wd[DATA_W-1:0];
        mk.iv      = iv;
        mk.ctx     = c[CTX_W-1:0];
        mk.loc     = loc;
        mk.last    = last;
        mk.w       = w[WEIGHT_W-1:0];
        mk.acc     = acc[ACC_W-1:0];
        mk.exp_val = ev[ACC_W-1:0];
        mk.exp_ovf = eo;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        npu_pe_new_input_wren = v.wren;
        npu_pe_wr_ctx         = v.wr_ctx;
        npu_pe_data_in        = v.wdata;
        npu_pe_in_valid       = v.iv;
        npu_pe_in_ctx         = v.ctx;
        npu_pe_in_local       = v.loc;
        npu_pe_in_last        = v.last;
        npu_pe_weight_in      = v.w;
        npu_pe_acc_in         = v.acc;
        if (v.iv) begin
            e.ctx  = v.ctx;
            e.val  = v.exp_val;
            e.last = v.last;
            e.ovf  = v.exp_ovf;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sb.size() != 0; k++) step();
        chk("drain_pending", sb.size(), 0);
    endtask

    // Results are consumed when out_valid is seen with en high
    always @(negedge CLK) begin
        exp_t e;
        if (!npu_rst && npu_pe_en && npu_pe_out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: acc_val=%0d, expected none",
                         npu_pe_acc_val);
            end else begin
                e = sb.pop_front();
                chk("acc_val", npu_pe_acc_val, e.val);
                chk("out_ctx", npu_pe_out_ctx, e.ctx);
                chk("out_last", npu_pe_out_last, e.last);
                chk("out_ovf", npu_pe_out_ovf, e.ovf);
                last_val = e.val;
                if (e.last) last_out = e.val;
                chk("acc_output", npu_pe_acc_output, last_out);
            end
        end
    end

    initial begin
        vec_t tbl[18];

        npu_rst   = 1'b1;
        npu_pe_en = 1'b1;
        idle();
        repeat (3) step();
        chk("rst_out_valid", npu_pe_out_valid, 0);
        chk("rst_out_ctx", npu_pe_out_ctx, 0);
        chk("rst_acc_val", npu_pe_acc_val, 0);
        chk("rst_acc_output", npu_pe_acc_output, 0);
        chk("rst_out_last", npu_pe_out_last, 0);
        chk("rst_out_ovf", npu_pe_out_ovf, 0);
        npu_rst = 1'b0;

        //           wr wc  wd   iv c lo la  w       acc   exp          ovf
        tbl[0]  = mk(1, 0, 3,     0, 0, 0, 0, 0,      0,    0,           0);
        tbl[1]  = mk(1, 1, 4,     1, 0, 0, 1, 5,      10,   25,          0);
        tbl[2]  = mk(1, 2, -2,    1, 0, 0, 0, -2,     100,  94,          0);
        tbl[3]  = mk(1, 3, 1000,  1, 1, 0, 0, 3,      -20,  -8,          0);
        tbl[4]  = mk(0, 0, 0,     1, 2, 1, 0, 1,      0,    -2,          0);
        tbl[5]  = mk(0, 0, 0,     1, 2, 1, 0, 2,      0,    -6,          0);
        tbl[6]  = mk(0, 0, 0,     1, 2, 1, 1, 3,      0,    -12,         0);
        tbl[7]  = mk(1, 1, 7,     1, 1, 0, 1, 1,      0,    4,           0);
        tbl[8]  = mk(0, 0, 0,     1, 1, 0, 1, 1,      0,    7,           0);
        tbl[9]  = mk(0, 0, 0,     1, 2, 1, 1, 1,      0,    -2,          0);
        tbl[10] = mk(0, 0, 0,     1, 3, 1, 0, -1,     0,    -1000,       0);
        tbl[11] = mk(0, 0, 0,     1, 0, 1, 0, 2,      0,    6,           0);
        tbl[12] = mk(0, 0, 0,     1, 3, 1, 1, -1,     0,    -2000,       0);
        tbl[13] = mk(1, 0, -32768,1, 0, 1, 1, 1,      0,    9,           0);
        tbl[14] = mk(1, 1, 1,     1, 0, 0, 1, -32768, -1,   1073741823,  0);
        tbl[15] = mk(0, 0, 0,     1, 1, 0, 1, 1,      PMAX, SAT ? PMAX : NMIN, SAT);
        tbl[16] = mk(0, 0, 0,     1, 1, 0, 1, -1,     NMIN, SAT ? NMIN : PMAX, SAT);
        tbl[17] = mk(0, 0, 0,     1, 1, 0, 1, -1,     PMAX, PMAX - 1,    0);

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i]);
            step();
        end
        idle();
        drain();

        // Stall with result A in the output register and B in flight
        apply(mk(0, 0, 0, 1, 3, 0, 1, 2, 5, 2005, 0));
        step();
        apply(mk(0, 0, 0, 1, 0, 1, 0, 1, 0, -32768, 0));
        step();
        idle();
        step();
        chk("stall_a_valid", npu_pe_out_valid, 1);
        chk("stall_a_val", npu_pe_acc_val, 2005);
        npu_pe_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("stall_hold_valid", npu_pe_out_valid, 1);
            chk("stall_hold_val", npu_pe_acc_val, 2005);
            chk("stall_hold_output", npu_pe_acc_output, 2005);
            chk("stall_hold_ctx", npu_pe_out_ctx, 3);
            chk("stall_hold_last", npu_pe_out_last, 1);
        end
        npu_pe_en = 1'b1;
        step();
        chk("stall_b_late_val", npu_pe_acc_val, -32768);
        chk("stall_b_late_ctx", npu_pe_out_ctx, 0);
        drain();
        chk("idle_acc_val_hold", npu_pe_acc_val, last_val);

        // Reset with two ops in flight and local_acc[0] non-zero
        apply(mk(0, 0, 0, 1, 1, 0, 1, 1, 3, 4, 0));
        step();
        apply(mk(0, 0, 0, 1, 2, 0, 1, 1, 0, -2, 0));
        step();
        idle();
        npu_rst = 1'b1;
        sb.delete();
        step();
        step();
        npu_rst  = 1'b0;
        last_out = '0;
        last_val = '0;
        for (int k = 0; k < 5; k++) begin
            chk("post_rst_valid", npu_pe_out_valid, 0);
            chk("post_rst_acc_val", npu_pe_acc_val, 0);
            chk("post_rst_acc_output", npu_pe_acc_output, 0);
            step();
        end
        apply(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        apply(mk(0, 0, 0, 1, 0, 1, 1, 1, 0, 5, 0));
        step();
        apply(mk(0, 0, 0, 1, 2, 0, 1, 1, 7, 7, 0));
        step();
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
